// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg: width/count helpers shared by the adder tree and its bench.
// No ports; provides level_width, level_count, popcount, tree_width, acc_width.
package adder_tree_pkg;

    // Operand width produced by tree level k (level 0 is the raw input).
    function automatic int level_width(int dw, int k);
        return dw + k;
    endfunction

    // Number of operands left after level k: ceil(n / 2^k).
    function automatic int level_count(int n, int k);
        return (n + (1 << k) - 1) >> k;
    endfunction

    // Number of register stages enabled in a pipeline mask.
    function automatic int popcount(int unsigned v);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int tree_width(int dw, int n);
        return dw + $clog2(n);
    endfunction

    function automatic int acc_width(int dw, int n, int extra);
        return tree_width(dw, n) + extra;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// adder_tree_level: one reduction level, pairwise adds with optional output register.
// Ports: clk, rst (sync, active-high), en (global advance), in_valid/in_last/in_data
// (N_IN operands of W_IN bits), out_valid/out_last/out_data (ceil(N_IN/2) x W_IN+1).
module adder_tree_level #(
    parameter int W_IN   = 8,
    parameter int N_IN   = 16,
    parameter int SIGNED = 0,
    parameter int ENABLE = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic                                 in_valid,
    input  logic                                 in_last,
    input  logic [N_IN*W_IN-1:0]                 in_data,
    output logic                                 out_valid,
    output logic                                 out_last,
    output logic [((N_IN+1)/2)*(W_IN+1)-1:0]     out_data
);
    localparam int W_OUT = W_IN + 1;
    localparam int N_OUT = (N_IN + 1) / 2;

    logic [N_OUT*W_OUT-1:0] sum;

    for (genvar i = 0; i < N_OUT; i++) begin : g_pair
        logic [W_IN-1:0]  a_raw;
        logic [W_OUT-1:0] a, b;
        assign a_raw = in_data[2*i*W_IN +: W_IN];
        assign a = {(SIGNED != 0) & a_raw[W_IN-1], a_raw};
        if (2*i + 1 < N_IN) begin : g_b
            logic [W_IN-1:0] b_raw;
            assign b_raw = in_data[(2*i+1)*W_IN +: W_IN];
            assign b = {(SIGNED != 0) & b_raw[W_IN-1], b_raw};
        end else begin : g_odd
            // odd leftover: adding zero just forwards the extended operand
            assign b = '0;
        end
        assign sum[i*W_OUT +: W_OUT] = a + b;
    end

    if (ENABLE != 0) begin : g_reg
        always_ff @(posedge clk)
            if (rst) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                out_data  <= '0;
            end else if (en) begin
                out_valid <= in_valid;
                out_last  <= in_last;
                out_data  <= sum;
            end
    end else begin : g_wire
        logic unused_ctl;
        assign unused_ctl = &{1'b0, clk, rst, en};
        assign out_valid  = in_valid;
        assign out_last   = in_last;
        assign out_data   = sum;
    end

endmodule

// File: rtl/adder_tree_accum.sv
// adder_tree_accum: pipelined NUM_INPUTS-way adder tree with multi-beat packet accumulator.
// Ports: clk, rst (sync, active-high); i_valid/i_ready/i_last/in_data input beat;
// o_valid/o_ready/o_sum packet result (ACC_W bits); o_overflow only with ADDER_TREE_ACC_SAT_EN.
// Macro ADDER_TREE_ACC_SAT_EN: saturate the accumulator and flag overflow instead of wrapping.
module adder_tree_accum
    import adder_tree_pkg::*;
#(
    parameter int          DATAWIDTH  = 8,
    parameter int          NUM_INPUTS = 16,
    parameter int          SIGNED     = 0,
    parameter int unsigned PIPE_MASK  = 1,
    parameter int          ACC_EXTRA  = 8,
    localparam int LEVELS = $clog2(NUM_INPUTS),
    localparam int TREE_W = tree_width(DATAWIDTH, NUM_INPUTS),
    localparam int ACC_W  = acc_width(DATAWIDTH, NUM_INPUTS, ACC_EXTRA)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_valid,
    output logic                            i_ready,
    input  logic                            i_last,
    input  logic [NUM_INPUTS*DATAWIDTH-1:0] in_data,
    output logic                            o_valid,
    input  logic                            o_ready,
    output logic [ACC_W-1:0]                o_sum
`ifdef ADDER_TREE_ACC_SAT_EN
   ,output logic                            o_overflow
`endif
);
    logic              en, t_valid, t_last;
    logic [TREE_W-1:0] tree;
    logic [ACC_W-1:0]  tree_ext, acc, sum_next;

    // Whole pipeline advances together whenever the output slot is free or draining.
    assign en      = !o_valid || o_ready;
    assign i_ready = en;

    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        localparam int W = level_width(DATAWIDTH, k) * level_count(NUM_INPUTS, k);
        logic [W-1:0] data;
        logic         valid, last;
        if (k == 0) begin : g_src
            if ((PIPE_MASK & 1) != 0) begin : g_reg
                always_ff @(posedge clk)
                    if (rst) begin
                        data  <= '0;
                        valid <= 1'b0;
                        last  <= 1'b0;
                    end else if (en) begin
                        data  <= in_data;
                        valid <= i_valid;
                        last  <= i_last;
                    end
            end else begin : g_wire
                assign data  = in_data;
                assign valid = i_valid;
                assign last  = i_last;
            end
        end else begin : g_add
            adder_tree_level #(
                .W_IN   (level_width(DATAWIDTH, k - 1)),
                .N_IN   (level_count(NUM_INPUTS, k - 1)),
                .SIGNED (SIGNED),
                .ENABLE (int'((PIPE_MASK >> k) & 1))
            ) u_level (
                .clk       (clk),
                .rst       (rst),
                .en        (en),
                .in_valid  (g_lvl[k-1].valid),
                .in_last   (g_lvl[k-1].last),
                .in_data   (g_lvl[k-1].data),
                .out_valid (valid),
                .out_last  (last),
                .out_data  (data)
            );
        end
    end

    assign tree     = g_lvl[LEVELS].data;
    assign t_valid  = g_lvl[LEVELS].valid;
    assign t_last   = g_lvl[LEVELS].last;
    assign tree_ext = (SIGNED != 0) ? ACC_W'($signed(tree)) : ACC_W'(tree);

`ifdef ADDER_TREE_ACC_SAT_EN
    logic [ACC_W:0] wide;
    logic           ovf, ovf_acc;
    // One guard bit makes the sum exact; overflow shows as a carry (unsigned)
    // or as disagreement between the guard bit and the result sign (signed).
    assign wide     = (SIGNED != 0) ? {acc[ACC_W-1], acc} + {tree_ext[ACC_W-1], tree_ext}
                                    : {1'b0, acc} + {1'b0, tree_ext};
    assign ovf      = (SIGNED != 0) ? wide[ACC_W] != wide[ACC_W-1] : wide[ACC_W];
    assign sum_next = !ovf ? wide[ACC_W-1:0]
                    : (SIGNED != 0) ? {wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}} : '1;

    always_ff @(posedge clk)
        if (rst) begin
            ovf_acc    <= 1'b0;
            o_overflow <= 1'b0;
        end else if (en && t_valid) begin
            ovf_acc <= !t_last && (ovf_acc || ovf);
            if (t_last) o_overflow <= ovf_acc || ovf;
        end
`else
    assign sum_next = acc + tree_ext;
`endif

    always_ff @(posedge clk)
        if (rst) begin
            acc     <= '0;
            o_sum   <= '0;
            o_valid <= 1'b0;
        end else if (en) begin
            o_valid <= t_valid && t_last;
            if (t_valid) begin
                acc <= t_last ? '0 : sum_next;
                if (t_last) o_sum <= sum_next;
            end
        end

endmodule

// File: tb/tb_adder_tree_accum.sv
// tb_adder_tree_accum: directed self-checking bench for adder_tree_accum in four configurations.
module tb_adder_tree_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // dut_a: 16x8 unsigned, PIPE_MASK=10101 (latency 4), ACC_W=20
    logic a_iv, a_ir, a_il, a_ov, a_or;
    logic [127:0] a_d;
    logic [19:0]  a_s;
    // dut_b: 5x4 unsigned, PIPE_MASK=1111 (latency 5), ACC_W=15
    logic b_iv, b_ir, b_il, b_ov, b_or;
    logic [19:0]  b_d;
    logic [14:0]  b_s;
    // dut_c: 16x8 signed, PIPE_MASK=1 (latency 2), ACC_W=20
    logic c_iv, c_ir, c_il, c_ov, c_or;
    logic [127:0] c_d;
    logic [19:0]  c_s;
    // dut_d: 2x4 unsigned, PIPE_MASK=0 (latency 1), ACC_EXTRA=0, ACC_W=5
    logic d_iv, d_ir, d_il, d_ov, d_or;
    logic [7:0]   d_d;
    logic [4:0]   d_s;
`ifdef ADDER_TREE_ACC_SAT_EN
    logic a_of, b_of, c_of, d_of;
`endif

    adder_tree_accum #(.DATAWIDTH(8), .NUM_INPUTS(16), .SIGNED(0), .PIPE_MASK(21), .ACC_EXTRA(8)) dut_a (
        .clk(clk), .rst(rst), .i_valid(a_iv), .i_ready(a_ir), .i_last(a_il), .in_data(a_d),
        .o_valid(a_ov), .o_ready(a_or), .o_sum(a_s)
`ifdef ADDER_TREE_ACC_SAT_EN
       ,.o_overflow(a_of)
`endif
    );
    adder_tree_accum #(.DATAWIDTH(4), .NUM_INPUTS(5), .SIGNED(0), .PIPE_MASK(15), .ACC_EXTRA(8)) dut_b (
        .clk(clk), .rst(rst), .i_valid(b_iv), .i_ready(b_ir), .i_last(b_il), .in_data(b_d),
        .o_valid(b_ov), .o_ready(b_or), .o_sum(b_s)
`ifdef ADDER_TREE_ACC_SAT_EN
       ,.o_overflow(b_of)
`endif
    );
    adder_tree_accum #(.DATAWIDTH(8), .NUM_INPUTS(16), .SIGNED(1), .PIPE_MASK(1), .ACC_EXTRA(8)) dut_c (
        .clk(clk), .rst(rst), .i_valid(c_iv), .i_ready(c_ir), .i_last(c_il), .in_data(c_d),
        .o_valid(c_ov), .o_ready(c_or), .o_sum(c_s)
`ifdef ADDER_TREE_ACC_SAT_EN
       ,.o_overflow(c_of)
`endif
    );
    adder_tree_accum #(.DATAWIDTH(4), .NUM_INPUTS(2), .SIGNED(0), .PIPE_MASK(0), .ACC_EXTRA(0)) dut_d (
        .clk(clk), .rst(rst), .i_valid(d_iv), .i_ready(d_ir), .i_last(d_il), .in_data(d_d),
        .o_valid(d_ov), .o_ready(d_or), .o_sum(d_s)
`ifdef ADDER_TREE_ACC_SAT_EN
       ,.o_overflow(d_of)
`endif
    );

    function automatic logic [127:0] fill8(input logic [7:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        {a_iv, b_iv, c_iv, d_iv} = '0;
        {a_il, b_il, c_il, d_il} = '0;
        {a_or, b_or, c_or, d_or} = '1;
        a_d = '0; b_d = '0; c_d = '0; d_d = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL reset a_o_valid got %0b exp 0", a_ov); end
        checks++; if (a_s !== 20'd0) begin errors++; $display("FAIL reset a_o_sum got %0d exp 0", a_s); end
        checks++; if (b_ov !== 1'b0 || b_s !== 15'd0) begin errors++; $display("FAIL reset b_out got v=%0b s=%0d exp v=0 s=0", b_ov, b_s); end
        checks++; if (c_ov !== 1'b0 || c_s !== 20'd0) begin errors++; $display("FAIL reset c_out got v=%0b s=%0d exp v=0 s=0", c_ov, c_s); end
        checks++; if (d_ov !== 1'b0 || d_s !== 5'd0) begin errors++; $display("FAIL reset d_out got v=%0b s=%0d exp v=0 s=0", d_ov, d_s); end
`ifdef ADDER_TREE_ACC_SAT_EN
        checks++; if (d_of !== 1'b0) begin errors++; $display("FAIL reset d_overflow got %0b exp 0", d_of); end
`endif
        a_or = 1'b0;
        #1;
        checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL reset a_i_ready got %0b exp 1", a_ir); end
        a_or = 1'b1;
    endtask

    task automatic test_odd_width();
        int cyc;
        @(negedge clk);
        b_iv = 1'b1; b_il = 1'b1; b_d = '1;
        cyc = 0;
        while (!b_ov && cyc < 20) begin @(negedge clk); cyc++; b_iv = 1'b0; end
        checks++; if (cyc != 5) begin errors++; $display("FAIL odd_latency got %0d exp 5", cyc); end
        checks++; if (b_s !== 15'd75) begin errors++; $display("FAIL odd_all15 got %0d exp 75", b_s); end
        @(negedge clk);
        checks++; if (b_ov !== 1'b0) begin errors++; $display("FAIL odd_drain o_valid got %0b exp 0", b_ov); end
        b_iv = 1'b1; b_d = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        cyc = 0;
        while (!b_ov && cyc < 20) begin @(negedge clk); cyc++; b_iv = 1'b0; end
        checks++; if (b_s !== 15'd15) begin errors++; $display("FAIL odd_ramp got %0d exp 15", b_s); end
        @(negedge clk);
    endtask

    task automatic test_signed();
        int cyc;
        c_iv = 1'b1; c_il = 1'b1; c_d = fill8(8'h80);
        cyc = 0;
        while (!c_ov && cyc < 20) begin @(negedge clk); cyc++; c_iv = 1'b0; end
        checks++; if (cyc != 2) begin errors++; $display("FAIL signed_latency got %0d exp 2", cyc); end
        checks++; if (c_s !== 20'hFF800) begin errors++; $display("FAIL signed_min got %h exp ff800", c_s); end
        @(negedge clk);
        c_iv = 1'b1; c_d = {fill8(8'hFF)[127:64], fill8(8'h7F)[63:0]};
        cyc = 0;
        while (!c_ov && cyc < 20) begin @(negedge clk); cyc++; c_iv = 1'b0; end
        checks++; if (c_s !== 20'd1008) begin errors++; $display("FAIL signed_mix got %0d exp 1008", c_s); end
        @(negedge clk);
    endtask

    task automatic test_multi_beat();
        int pulses, at;
        logic [19:0] got;
        pulses = 0; at = -1; got = '0; a_or = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            if (a_ov) begin pulses++; got = a_s; at = cyc; end
            a_iv = cyc < 3; a_il = cyc == 2; a_d = fill8(8'd1);
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL multi_pulses got %0d exp 1", pulses); end
        checks++; if (got !== 20'd48) begin errors++; $display("FAIL multi_sum got %0d exp 48", got); end
        checks++; if (at != 6) begin errors++; $display("FAIL multi_latency got cycle %0d exp 6", at); end
        pulses = 0; got = '0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (a_ov) begin pulses++; got = a_s; end
            a_iv = cyc == 0; a_il = 1'b1; a_d = fill8(8'd2);
        end
        checks++; if (pulses != 1 || got !== 20'd32) begin errors++; $display("FAIL multi_cleared got pulses=%0d sum=%0d exp 1/32", pulses, got); end
    endtask

    task automatic test_back_to_back();
        int sent, got, cyc;
        logic will, stall;
        logic [19:0] held;
        sent = 0; got = 0; cyc = 0; will = 0; stall = 0; held = '0;
        while (got < 6 && cyc < 60) begin
            @(negedge clk);
            if (will) sent++;
            a_or = !(cyc >= 4 && cyc <= 8);
            a_iv = sent < 6; a_il = 1'b1; a_d = fill8(8'(sent + 1));
            #1;
            checks++; if (a_ir !== (!a_ov || a_or)) begin errors++; $display("FAIL b2b_i_ready cyc %0d got %0b exp %0b", cyc, a_ir, !a_ov || a_or); end
            if (stall) begin
                checks++; if (a_ov !== 1'b1 || a_s !== held) begin errors++; $display("FAIL b2b_hold cyc %0d got v=%0b s=%0d exp v=1 s=%0d", cyc, a_ov, a_s, held); end
            end
            if (a_ov && a_or) begin
                checks++; if (a_s !== 20'(16 * (got + 1))) begin errors++; $display("FAIL b2b_order #%0d got %0d exp %0d", got, a_s, 16 * (got + 1)); end
                got++;
            end
            will = a_iv && a_ir;
            stall = a_ov && !a_or; held = a_s;
            cyc++;
        end
        checks++; if (got != 6) begin errors++; $display("FAIL b2b_count got %0d exp 6", got); end
        a_iv = 1'b0; a_or = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL b2b_extra o_valid got %0b exp 0", a_ov); end
    endtask

    task automatic test_mid_reset();
        int cyc;
        a_or = 1'b1;
        @(negedge clk); a_iv = 1'b1; a_il = 1'b0; a_d = fill8(8'd5);
        @(negedge clk);
        @(negedge clk); rst = 1'b1; a_iv = 1'b0;
        @(negedge clk);
        checks++; if (a_ov !== 1'b0 || a_s !== 20'd0) begin errors++; $display("FAIL midrst_clear got v=%0b s=%0d exp 0/0", a_ov, a_s); end
        rst = 1'b0; a_iv = 1'b1; a_il = 1'b1; a_d = fill8(8'd1);
        cyc = 0;
        while (!a_ov && cyc < 10) begin @(negedge clk); cyc++; a_iv = 1'b0; end
        checks++; if (a_ov !== 1'b1 || cyc != 4) begin errors++; $display("FAIL midrst_latency got v=%0b cyc=%0d exp 1/4", a_ov, cyc); end
        checks++; if (a_s !== 20'd16) begin errors++; $display("FAIL midrst_sum got %0d exp 16", a_s); end
        @(negedge clk);
    endtask

    task automatic test_saturate();
        int cyc;
        d_or = 1'b1;
        d_iv = 1'b1; d_il = 1'b0; d_d = 8'hFF;
        @(negedge clk); d_il = 1'b1;
        cyc = 0;
        while (!d_ov && cyc < 5) begin @(negedge clk); cyc++; d_iv = 1'b0; end
        checks++; if (cyc != 1) begin errors++; $display("FAIL sat_latency got %0d exp 1", cyc); end
`ifdef ADDER_TREE_ACC_SAT_EN
        checks++; if (d_s !== 5'd31) begin errors++; $display("FAIL sat_sum got %0d exp 31", d_s); end
        checks++; if (d_of !== 1'b1) begin errors++; $display("FAIL sat_flag got %0b exp 1", d_of); end
`else
        checks++; if (d_s !== 5'd28) begin errors++; $display("FAIL wrap_sum got %0d exp 28", d_s); end
`endif
        @(negedge clk);
        d_iv = 1'b1; d_il = 1'b1; d_d = {4'd1, 4'd1};
        cyc = 0;
        while (!d_ov && cyc < 5) begin @(negedge clk); cyc++; d_iv = 1'b0; end
        checks++; if (d_s !== 5'd2) begin errors++; $display("FAIL sat_next_sum got %0d exp 2", d_s); end
`ifdef ADDER_TREE_ACC_SAT_EN
        checks++; if (d_of !== 1'b0) begin errors++; $display("FAIL sat_flag_clear got %0b exp 0", d_of); end
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_odd_width();
        test_signed();
        test_multi_beat();
        test_back_to_back();
        test_mid_reset();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
